perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised performance-counter bank for the RV32I pipeline: one free-running cycle counter plus `NUM_EVENTS` event counters fed by single-cycle event strobes (retire, stall, bubble, flush, forward, branch, and so on). It supports:
- freezing on program halt;
- atomic snapshot into shadow registers;
- a registered read port for testbench or MMIO readout.

It replaces the fixed-width, fixed-event-set monitor attached to the core and adds wrap/saturate modes, sticky overflow, and consistent multi-counter readout.

## Interface
- `NUM_EVENTS`, default 8: number of event counters, 1..32.
- `CNT_WIDTH`, default 32: width of every counter, 8..64.
- `SATURATE`, default 0: 0 means counters wrap to 0; 1 means counters hold at all-ones.
- `SEL_W`, default 4: read-select width; must satisfy 2^SEL_W > NUM_EVENTS.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `event_in`  in  NUM_EVENTS  per-event increment strobe; bit i increments counter i.
- `count_en`  in  1  global run enable.
- `halt`  in  1  program-finished strobe (EBREAK/ECALL at WB); sets frozen.
- `clear`  in  1  synchronous clear of live counters, overflow flags and frozen.
- `snap_req`  in  1  copy all live counters into shadow registers.
- `snap_done`  out  1  one-cycle pulse, the cycle after the snapshot is taken.
- `rd_en`  in  1  read request.
- `rd_sel`  in  SEL_W  index selection:
  - 0..NUM_EVENTS-1 selects the corresponding event counter;
  - NUM_EVENTS selects the cycle counter;
  - any other value reads as 0.
- `rd_valid`  out  1  read data valid.
- `rd_data`  out  CNT_WIDTH  selected shadow value.
- `overflow`  out  NUM_EVENTS+1  sticky overflow flags; bit NUM_EVENTS belongs to the cycle counter.
- `frozen`  out  1  counters halted by `halt`.

## Operation
- **Reset:** `rst` asserted clears all live counters, shadows, `overflow`, `frozen`, `snap_done`, `rd_valid` and `rd_data` to 0 immediately, without waiting for a clock edge. Assertion mid-operation discards all state.
- **Running condition:** `running = count_en && !frozen`.
- **Cycle counter:** increments by 1 on every edge where `running` is true.
- **Event counters:** counter i increments by 1 on every edge where `running && event_in[i]` is true. There is at most one increment per counter per cycle.
- **Terminal value:** a counter at all-ones (2^CNT_WIDTH-1) that receives an increment:
  - with `SATURATE=0`, wraps to 0;
  - with `SATURATE=1`, stays at all-ones.
  - In both modes the counter's `overflow` bit is set. It stays set until `clear` or `rst`.
- **Freeze:**
  - `halt` sets `frozen` at the next edge.
  - Events presented in the same cycle as `halt` are still counted.
  - `frozen` stays set regardless of further `halt` pulses. Only `clear` or `rst` releases it.
- **Clear:** on the edge where `clear` is high, live counters, `overflow` and `frozen` become 0. Increments in that cycle are discarded: clear has priority over increments and over `halt`.
- **Snapshot:**
  - On the edge where `snap_req` is high, each shadow register takes its live counter's register value as it stood before that edge, excluding any increment applied on the same edge.
  - `snap_done` pulses on the following cycle.
  - `snap_req` together with `clear`: shadows capture the pre-clear values and the live counters clear.
  - `snap_req` while frozen is legal and captures the frozen values.
- **Read:**
  - Reads always return shadow values, never live values, so multi-counter readout is mutually consistent.
  - `rd_sel` out of range returns 0 with `rd_valid` still asserted.
- **Back-to-back activity:** back-to-back `rd_en` and `snap_req` are supported every cycle with no stall.

## Timing
- **Read latency:** 1 cycle. `rd_en` and `rd_sel` are sampled at edge N; `rd_valid` and `rd_data` are valid after edge N, during cycle N+1. If `rd_en` is low at edge N, `rd_valid` is 0 in the following cycle and `rd_data` holds its last value.
- **Read and snapshot on the same edge:** `rd_data` returns the old shadow value. The new value is visible to reads issued from the next cycle.
- **Snapshot latency:** snapshot at edge N; `snap_done` is high for exactly the cycle following edge N.
- **Status flags:** `overflow` and `frozen` are registered and change only at edges, or asynchronously on `rst`.
- **Datapath:** no combinational path from any input to any output. All outputs are driven directly from flops.

## Test plan
Parameters for all scenarios: NUM_EVENTS=4, CNT_WIDTH=8.
1. **Reset and basic count:** assert `rst` mid-clock; all outputs read 0 before the next edge. Then hold `count_en`=1 for 10 cycles with `event_in`=4'b0101, snap, and read sel 0, 1, 2, 4 → 10, 0, 10, 10, each with `rd_valid` exactly one cycle after `rd_en`.
2. **Wrap vs saturate:** with `SATURATE=0`, 300 strobes on event 3 → counter reads 44 and `overflow[3]`=1. With `SATURATE=1`, the same stimulus → 255 and `overflow[3]`=1. `clear` → `overflow`=0.
3. **Halt freeze:**
   - Run 5 cycles with `event_in[0]`=1 and `halt` on cycle 5 → counter 0 reads 5 and `frozen`=1.
   - 20 further strobes leave it at 5.
   - `clear` → `frozen`=0 and counting resumes from 0.
4. **Snapshot consistency:**
   - Counting continuously, `snap_req` when the cycle counter register is 17 → read sel 4 returns 17 on every subsequent read while live counting continues.
   - `snap_done` is high for one cycle.
5. **Simultaneous events:**
   - `snap_req`+`clear` with counter 0 at 9 → shadow 9, live 0.
   - `rd_en`+`snap_req` on the same edge returns the prior shadow value.
   - `clear` with `event_in`=4'hF leaves all counters at 0.
6. **Out-of-range read:** `rd_sel`=7 → `rd_data`=0 and `rd_valid`=1. `count_en`=0 for 8 cycles → no counter changes.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance-counter bank: one free-running cycle counter plus NUM_EVENTS event
// counters, with freeze-on-halt, atomic shadow snapshot and a registered read port.
module perf_counter_bank #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int SATURATE   = 0,
  parameter int SEL_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  count_en,
  input  logic                  halt,
  input  logic                  clear,
  input  logic                  snap_req,
  output logic                  snap_done,
  input  logic                  rd_en,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [NUM_EVENTS:0]   overflow,
  output logic                  frozen
);

  // Slot NUM_EVENTS of every array is the cycle counter, matching the overflow layout.
  localparam int NCNT = NUM_EVENTS + 1;

  logic [CNT_WIDTH-1:0] cnt_q    [NCNT];
  logic [CNT_WIDTH-1:0] cnt_d    [NCNT];
  logic [CNT_WIDTH-1:0] shadow_q [NCNT];
  logic [NCNT-1:0]      ovf_q, ovf_d;
  logic [NCNT-1:0]      incVec;
  logic                 running;
  logic                 frozen_q, frozen_d;
  logic                 snapDone_q;
  logic                 rdValid_q;
  logic [CNT_WIDTH-1:0] rdData_q, rdMux;

  assign running  = count_en & ~frozen_q;
  assign incVec   = {running, event_in & {NUM_EVENTS{running}}};
  assign frozen_d = clear ? 1'b0 : (frozen_q | halt);

  // Clear wins over any increment; the terminal value wraps or sticks per SATURATE.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (incVec[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? '1 : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
    if (clear) ovf_d = '0;
  end

  always_comb begin
    rdMux = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel == SEL_W'(i)) rdMux = shadow_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q      <= '0;
      frozen_q   <= 1'b0;
      snapDone_q <= 1'b0;
      rdValid_q  <= 1'b0;
      rdData_q   <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        // Shadows take the pre-edge live value, so a same-edge read still sees the old shadow.
        if (snap_req) shadow_q[i] <= cnt_q[i];
      end
      ovf_q      <= ovf_d;
      frozen_q   <= frozen_d;
      snapDone_q <= snap_req;
      rdValid_q  <= rd_en;
      if (rd_en) rdData_q <= rdMux;
    end
  end

  assign snap_done = snapDone_q;
  assign rd_valid  = rdValid_q;
  assign rd_data   = rdData_q;
  assign overflow  = ovf_q;
  assign frozen    = frozen_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomised and directed bench for perf_counter_bank, comparing a wrapping and a
// saturating instance against an arithmetic reference model every cycle.
module tb_perf_counter_bank;

  localparam int NE = 4;
  localparam int CW = 8;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic [NE-1:0] event_in;
  logic          count_en, halt, clear, snap_req, rd_en;
  logic [SW-1:0] rd_sel;

  logic          snapDoneW, rdValidW, frozenW;
  logic [CW-1:0] rdDataW;
  logic [NE:0]   overflowW;
  logic          snapDoneS, rdValidS, frozenS;
  logic [CW-1:0] rdDataS;
  logic [NE:0]   overflowS;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: index 0 = wrapping instance, 1 = saturating instance.
  int         liveM   [2][NE+1];
  int         shadowM [2][NE+1];
  logic [NE:0] ovfM   [2];
  int         expRd   [2];
  bit         frozenM;
  bit         expValid;
  bit         expDone;

  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SATURATE(0), .SEL_W(SW)) dutWrap (
    .clk(clk), .rst(rst), .event_in(event_in), .count_en(count_en), .halt(halt),
    .clear(clear), .snap_req(snap_req), .snap_done(snapDoneW), .rd_en(rd_en),
    .rd_sel(rd_sel), .rd_valid(rdValidW), .rd_data(rdDataW), .overflow(overflowW),
    .frozen(frozenW)
  );

  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SATURATE(1), .SEL_W(SW)) dutSat (
    .clk(clk), .rst(rst), .event_in(event_in), .count_en(count_en), .halt(halt),
    .clear(clear), .snap_req(snap_req), .snap_done(snapDoneS), .rd_en(rd_en),
    .rd_sel(rd_sel), .rd_valid(rdValidS), .rd_data(rdDataS), .overflow(overflowS),
    .frozen(frozenS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k <= NE; k++) begin
        liveM[m][k]   = 0;
        shadowM[m][k] = 0;
      end
      ovfM[m]  = '0;
      expRd[m] = 0;
    end
    frozenM  = 0;
    expValid = 0;
    expDone  = 0;
  endtask

  task automatic compareAll();
    checkOutput("rdValidW",  rdValidW,  expValid);
    checkOutput("rdValidS",  rdValidS,  expValid);
    checkOutput("rdDataW",   rdDataW,   expRd[0]);
    checkOutput("rdDataS",   rdDataS,   expRd[1]);
    checkOutput("snapDoneW", snapDoneW, expDone);
    checkOutput("snapDoneS", snapDoneS, expDone);
    checkOutput("overflowW", overflowW, ovfM[0]);
    checkOutput("overflowS", overflowS, ovfM[1]);
    checkOutput("frozenW",   frozenW,   frozenM);
    checkOutput("frozenS",   frozenS,   frozenM);
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then compare.
  task automatic applyStimulus(input logic [NE-1:0] ev, input bit cen, input bit hlt,
                               input bit clr, input bit snap, input bit rden,
                               input logic [SW-1:0] sel);
    bit running;
    int idx;
    event_in = ev;
    count_en = cen;
    halt     = hlt;
    clear    = clr;
    snap_req = snap;
    rd_en    = rden;
    rd_sel   = sel;
    idx      = int'(sel);
    running  = cen && !frozenM;
    expValid = rden;
    expDone  = snap;
    for (int m = 0; m < 2; m++) begin
      if (rden) expRd[m] = (idx <= NE) ? shadowM[m][idx] : 0;
      if (snap) for (int k = 0; k <= NE; k++) shadowM[m][k] = liveM[m][k];
      for (int k = 0; k <= NE; k++) begin
        if (clr) begin
          liveM[m][k] = 0;
        end else if (running && (k == NE || ev[k])) begin
          if (liveM[m][k] == 255) begin
            ovfM[m][k]  = 1'b1;
            liveM[m][k] = (m == 1) ? 255 : 0;
          end else begin
            liveM[m][k] = liveM[m][k] + 1;
          end
        end
      end
      if (clr) ovfM[m] = '0;
    end
    if (clr) frozenM = 0;
    else if (hlt) frozenM = 1;
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic readSel(input logic [SW-1:0] sel, input string tag, input int expW, input int expS);
    applyStimulus('0, 0, 0, 0, 0, 1, sel);
    checkOutput({tag, "W"}, rdDataW, expW);
    checkOutput({tag, "S"}, rdDataS, expS);
  endtask

  initial begin
    rst      = 1'b1;
    event_in = '0;
    count_en = 0;
    halt     = 0;
    clear    = 0;
    snap_req = 0;
    rd_en    = 0;
    rd_sel   = '0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compareAll();

    // Build up some state, then assert reset between edges.
    for (int i = 0; i < 6; i++) applyStimulus(4'hF, 1, 0, 0, (i == 4), 1, 4'(i % 5));
    #2;
    rst = 1'b1;
    #1;
    resetModel();
    checkOutput("rstRdData",   rdDataW,   0);
    checkOutput("rstRdValid",  rdValidW,  0);
    checkOutput("rstOverflow", overflowW, 0);
    checkOutput("rstFrozen",   frozenW,   0);
    checkOutput("rstSnapDone", snapDoneW, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compareAll();

    // Basic count: events 0 and 2 for ten cycles.
    for (int i = 0; i < 10; i++) applyStimulus(4'b0101, 1, 0, 0, 0, 0, '0);
    applyStimulus('0, 0, 0, 0, 1, 0, '0);
    readSel(4'd0, "basicEv0", 10, 10);
    readSel(4'd1, "basicEv1", 0, 0);
    readSel(4'd2, "basicEv2", 10, 10);
    readSel(4'd4, "basicCyc", 10, 10);
    idle(1);

    // Wrap versus saturate on event 3.
    applyStimulus('0, 0, 0, 1, 0, 0, '0);
    for (int i = 0; i < 300; i++) applyStimulus(4'b1000, 1, 0, 0, 0, 0, '0);
    applyStimulus('0, 0, 0, 0, 1, 0, '0);
    readSel(4'd3, "wrapSatEv3", 44, 255);
    checkOutput("ovf3W", overflowW[3], 1);
    checkOutput("ovf3S", overflowS[3], 1);
    applyStimulus('0, 0, 0, 1, 0, 0, '0);
    checkOutput("ovfClearW", overflowW, 0);

    // Halt freeze: halt on the fifth counting cycle still counts.
    for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 1, (i == 4), 0, 0, 0, '0);
    checkOutput("frozenSet", frozenW, 1);
    for (int i = 0; i < 20; i++) applyStimulus(4'b0001, 1, 0, 0, 0, 0, '0);
    applyStimulus('0, 0, 0, 0, 1, 0, '0);
    readSel(4'd0, "frozenEv0", 5, 5);
    applyStimulus('0, 0, 0, 1, 0, 0, '0);
    checkOutput("frozenClear", frozenW, 0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 1, 0, 0, 0, 0, '0);
    applyStimulus('0, 0, 0, 0, 1, 0, '0);
    readSel(4'd0, "resumeEv0", 3, 3);

    // Snapshot consistency while counting continues.
    applyStimulus('0, 0, 0, 1, 0, 0, '0);
    for (int i = 0; i < 17; i++) applyStimulus('0, 1, 0, 0, 0, 0, '0);
    applyStimulus('0, 1, 0, 0, 1, 0, '0);
    checkOutput("snapDonePulse", snapDoneW, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus('0, 1, 0, 0, 0, 1, 4'd4);
      checkOutput("snapCyc17", rdDataW, 17);
    end
    checkOutput("snapDoneLow", snapDoneW, 0);

    // Snapshot with clear, read with snapshot, clear with events.
    applyStimulus('0, 0, 0, 1, 0, 0, '0);
    for (int i = 0; i < 9; i++) applyStimulus(4'b0001, 1, 0, 0, 0, 0, '0);
    applyStimulus('0, 0, 0, 1, 1, 0, '0);
    readSel(4'd0, "snapClrEv0", 9, 9);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 1, 0, 0, 0, 0, '0);
    applyStimulus('0, 0, 0, 0, 1, 1, 4'd0);
    checkOutput("rdSnapOld", rdDataW, 9);
    readSel(4'd0, "rdSnapNew", 3, 3);
    applyStimulus(4'hF, 1, 0, 1, 0, 0, '0);
    applyStimulus('0, 0, 0, 0, 1, 0, '0);
    for (int k = 0; k <= NE; k++) readSel(4'(k), "clrEvF", 0, 0);

    // Out-of-range read and disabled counting.
    for (int i = 0; i < 4; i++) applyStimulus(4'b0110, 1, 0, 0, 0, 0, '0);
    applyStimulus('0, 0, 0, 0, 1, 1, 4'd7);
    checkOutput("oorData",  rdDataW,  0);
    checkOutput("oorValid", rdValidW, 1);
    for (int i = 0; i < 8; i++) applyStimulus(4'hF, 0, 0, 0, 0, 0, '0);
    applyStimulus('0, 0, 0, 0, 1, 0, '0);
    readSel(4'd1, "cenOffEv1", 4, 4);
    readSel(4'd4, "cenOffCyc", 4, 4);

    // Randomised traffic with rare clears and halts.
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(4'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
